fetch_pc_ctrl: RTL
==================

Name: fetch_pc_ctrl

Overview:
Sequencer for the fetch stage. It owns the architectural PC register and issues instruction-memory requests. It chooses the next PC by fixed priority: redirect target (from the branch-target unit), halt, stall, or sequential increment. It also generates the flush pulse that kills the wrong-path fetch after a redirect.

Parameters:
PC_BITS, 16, width of PC and all address ports
RESET_PC, 16'h0000, PC value loaded on reset
PC_INC, 1, sequential increment per accepted fetch (word-addressed memory)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall_i  input  1  downstream stall; hold PC, suppress request
redirect_valid_i  input  1  taken branch/jump/JR resolved this cycle
redirect_pc_i  input  PC_BITS  redirect target from branch-target unit
halt_i  input  1  halt instruction decoded; stop fetching
imem_ready_i  input  1  instruction memory accepts request this cycle
imem_req_o  output  1  fetch request valid
pc_o  output  PC_BITS  address of current request (PC register)
fetch_valid_o  output  1  registered: fetch accepted last cycle and not killed
fetch_pc_o  output  PC_BITS  PC of the fetch flagged by fetch_valid_o
flush_o  output  1  registered one-cycle pulse after a redirect
halted_o  output  1  high while in HALT

Behaviour:
- Clocking and reset: single clock clk; asynchronous active-low reset rst_n.
- Reset values: pc=RESET_PC, state=BOOT, imem_req_o=0, fetch_valid_o=0, fetch_pc_o=0, flush_o=0, halted_o=0.
- Reset asserted mid-operation: every register returns to its reset value immediately; any in-flight fetch is lost and no fetch_valid_o is produced for it.
- States:
  - BOOT: one cycle, no request; goes to RUN unconditionally.
  - RUN: normal fetching.
  - WAIT: request issued but not accepted.
  - HALT: idle.
- imem_req_o = (state is RUN or WAIT) && !stall_i && !redirect_valid_i. This is the only combinational output.
- Accept = imem_req_o && imem_ready_i.
- Next-PC priority, evaluated in RUN/WAIT/HALT:
  1. redirect_valid_i: pc<=redirect_pc_i; state<=RUN; flush_o<=1 next cycle; fetch_valid_o<=0 next cycle.
  2. halt_i: pc held; state<=HALT; halted_o<=1 next cycle; fetch_valid_o<=0 next cycle.
  3. stall_i: pc held; state unchanged; fetch_valid_o<=0.
  4. Accept: pc<=pc+PC_INC, truncated to PC_BITS (wrap 0xFFFF->0x0000 at default); fetch_pc_o<=pc; fetch_valid_o<=1; state<=RUN.
  5. Request not accepted: pc held; state<=WAIT; fetch_valid_o<=0. The request stays asserted with a stable pc_o until accepted.
- Latency: fetch_valid_o and fetch_pc_o follow acceptance by exactly one cycle.
- Flush timing:
  - flush_o is high for exactly one cycle per redirect cycle. Back-to-back redirects give back-to-back pulses.
  - The first request at the new target is issued the cycle after the redirect.
- HALT:
  - imem_req_o=0 and pc frozen.
  - Exited only by redirect_valid_i (resume at target, halted_o<=0) or by reset.
  - halt_i while already in HALT has no effect.
- redirect_valid_i during BOOT is ignored; BOOT always fetches RESET_PC first.
- Simultaneous redirect+halt: redirect wins. The halt belongs to the flushed wrong path.
- Stall during WAIT: the request drops; pc is held; resumes when stall_i falls.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined:
  - Adds output fetch_count_o (32 bits), reset 0.
  - Increments on every Accept that is not overridden by redirect/halt, saturating at 32'hFFFF_FFFF.
  - Adds output redirect_count_o (16 bits), counting redirect cycles and saturating.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Decomposition:
- fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {BOOT, RUN, WAIT, HALT};
  - localparam default PC width;
  - localparam CNT_W=32.
- One natural sub-module, pc_next_sel: purely combinational priority mux producing next_pc, next_state, and the accept/kill flags. The parent holds all registers.

Test Plan:
- Reset release with imem_ready_i=1, no other inputs: BOOT for 1 cycle, then pc_o=0,1,2,3 on successive cycles; fetch_valid_o first high 1 cycle after the first accept, with fetch_pc_o=0.
- imem_ready_i=0 for 3 cycles at pc=5: imem_req_o held high, pc_o stable at 5, fetch_valid_o=0; on ready, fetch_pc_o=5 next cycle and pc_o=6.
- redirect_valid_i=1 with redirect_pc_i=0x0040 while pc=0x0010 and ready=1: imem_req_o=0 that cycle; next cycle flush_o=1, fetch_valid_o=0, pc_o=0x0040; flush_o low the cycle after.
- halt_i=1 at pc=7: next cycle halted_o=1, imem_req_o=0, pc frozen at 7 for 10 cycles; redirect to 0x0100 -> halted_o=0, pc_o=0x0100, flush_o pulse.
- PC wrap: force pc=0xFFFF via redirect, accept -> pc_o=0x0000, fetch_pc_o=0xFFFF; simultaneous redirect+halt -> redirect taken, halted_o stays 0.
- rst_n asserted during WAIT with stall_i=1: all outputs reset asynchronously; after release, BOOT then fetch from RESET_PC. With FETCH_PERF_CNT_EN, 5 accepts give fetch_count_o=5.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    WAIT,
    HALT
  } fetch_state_t;

  localparam int unsigned FETCH_PC_BITS = 16;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned RCNT_W        = 16;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC / next-state priority mux for the fetch sequencer.
// Priority: redirect > halt > stall > accept > hold in WAIT. BOOT ignores all inputs.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter int unsigned PC_BITS = FETCH_PC_BITS,
  parameter int unsigned PC_INC  = 1
) (
  input  fetch_state_t       state_i,
  input  logic [PC_BITS-1:0] pc_i,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [PC_BITS-1:0] redirect_pc_i,
  input  logic               halt_i,
  input  logic               imem_ready_i,
  output logic               req_o,
  output logic [PC_BITS-1:0] next_pc_o,
  output fetch_state_t       next_state_o,
  output logic               fetch_fire_o,
  output logic               flush_fire_o
);

  logic accept;

  // Request qualification and fixed-priority next-state selection.
  always_comb begin
    req_o        = ((state_i == RUN) || (state_i == WAIT)) && !stall_i && !redirect_valid_i;
    accept       = req_o && imem_ready_i;
    next_pc_o    = pc_i;
    next_state_o = state_i;
    fetch_fire_o = 1'b0;
    flush_fire_o = 1'b0;
    if (state_i == BOOT) begin
      next_state_o = RUN;
    end else if (redirect_valid_i) begin
      next_pc_o    = redirect_pc_i;
      next_state_o = RUN;
      flush_fire_o = 1'b1;
    end else if (halt_i) begin
      next_state_o = HALT;
    end else if (state_i == HALT) begin
      next_state_o = HALT;
    end else if (stall_i) begin
      next_state_o = state_i;
    end else if (accept) begin
      next_pc_o    = pc_i + PC_BITS'(PC_INC);
      next_state_o = RUN;
      fetch_fire_o = 1'b1;
    end else begin
      next_state_o = WAIT;
    end
  end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: owns the PC register, issues imem requests,
// reports accepted fetches one cycle later and pulses flush after a redirect.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned             PC_BITS  = FETCH_PC_BITS,
  parameter logic [PC_BITS-1:0]      RESET_PC = '0,
  parameter int unsigned             PC_INC   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_valid_i,
  input  logic [PC_BITS-1:0] redirect_pc_i,
  input  logic               halt_i,
  input  logic               imem_ready_i,
  output logic               imem_req_o,
  output logic [PC_BITS-1:0] pc_o,
  output logic               fetch_valid_o,
  output logic [PC_BITS-1:0] fetch_pc_o,
  output logic               flush_o,
  output logic               halted_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]   fetch_count_o,
  output logic [RCNT_W-1:0]  redirect_count_o
`endif
);

  fetch_state_t       state_q, state_d;
  logic [PC_BITS-1:0] pc_q, pc_d;
  logic [PC_BITS-1:0] fetch_pc_q;
  logic               fetch_valid_q, flush_q, halted_q;
  logic               fetch_fire, flush_fire;

  pc_next_sel #(
    .PC_BITS (PC_BITS),
    .PC_INC  (PC_INC)
  ) u_sel (
    .state_i          (state_q),
    .pc_i             (pc_q),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .halt_i           (halt_i),
    .imem_ready_i     (imem_ready_i),
    .req_o            (imem_req_o),
    .next_pc_o        (pc_d),
    .next_state_o     (state_d),
    .fetch_fire_o     (fetch_fire),
    .flush_fire_o     (flush_fire)
  );

  // State, PC and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      fetch_pc_q    <= '0;
      flush_q       <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_fire;
      flush_q       <= flush_fire;
      halted_q      <= (state_d == HALT);
      if (fetch_fire) fetch_pc_q <= pc_q;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = fetch_valid_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign flush_o       = flush_q;
  assign halted_o      = halted_q;

`ifdef FETCH_PERF_CNT_EN
  logic [CNT_W-1:0]  fetch_cnt_q;
  logic [RCNT_W-1:0] redir_cnt_q;

  // Saturating counters of committed fetches and taken redirects.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (fetch_fire && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 1'b1;
      if (flush_fire && (redir_cnt_q != '1)) redir_cnt_q <= redir_cnt_q + 1'b1;
    end
  end

  assign fetch_count_o    = fetch_cnt_q;
  assign redirect_count_o = redir_cnt_q;
`endif

endmodule
